// File: rtl/pc_fetch_unit.sv
// Architectural PC and fetch sequencer: one imem fetch per retired instruction, handed to decode.
// gnt@t, rvalid@t+1 -> inst_valid@t+2; stalls on gnt, rvalid and inst_ready; fetch issued the cycle after pc_write.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        pc_write,
    input  logic [31:0] next_pc,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        fault,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_VALID,
        S_EXEC,
        S_FAULT,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        fault_q, fault_d;
    logic        halted_q, halted_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        fetch_count_d = fetch_count_q;
        fault_d       = fault_q;
        halted_d      = halted_q;
        case (state_q)
            S_REQ: begin
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = S_VALID;
                end
            end
            S_VALID: begin
                if (inst_ready) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                // The PC is committed even when the retire halts or faults.
                if (pc_write) begin
                    pc_d = next_pc;
                    if (halt) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_FAULT, S_HALT: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            inst_q        <= 32'd0;
            inst_pc_q     <= 32'd0;
            fetch_count_q <= 32'd0;
            fault_q       <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            fetch_count_q <= fetch_count_d;
            fault_q       <= fault_d;
            halted_q      <= halted_d;
        end
    end

    // Handshake outputs are masked while reset is asserted so nothing leaks out mid-reset.
    assign imem_req    = reset && (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign inst_valid  = reset && (state_q == S_VALID);
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign pc          = pc_q;
    assign fault       = fault_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        pc_write;
    logic [31:0] next_pc;
    logic        halt;
    logic [31:0] pc;
    logic        fault;
    logic        halted;
    logic [31:0] fetch_count;

    int checks;
    int errors;

    pc_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .pc_write    (pc_write),
        .next_pc     (next_pc),
        .halt        (halt),
        .pc          (pc),
        .fault       (fault),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic fetch_to_valid(input logic [31:0] data);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic accept();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic retire(input logic [31:0] npc, input logic h);
        pc_write = 1'b1;
        next_pc  = npc;
        halt     = h;
        tick();
        pc_write = 1'b0;
        halt     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h expected 00000100", pc); end
        checks++; if ({fault, halted} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %b expected 00", {fault, halted}); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected 0", fetch_count); end
        checks++; if ({inst, inst_pc} !== 64'd0) begin errors++; $display("FAIL reset_inst: got %h expected 0", {inst, inst_pc}); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL first_req: got req=%b addr=%h expected 1 00000100", imem_req, imem_addr); end
    endtask

    task automatic test_basic_fetch();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wait_req: got %b expected 0", imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", inst_valid); end
        checks++; if (inst !== 32'h0050_0093) begin errors++; $display("FAIL basic_inst: got %h expected 00500093", inst); end
        checks++; if (inst_pc !== 32'h100) begin errors++; $display("FAIL basic_inst_pc: got %h expected 00000100", inst_pc); end
        accept();
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", fetch_count); end
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL exec_idle: got valid=%b req=%b expected 0 0", inst_valid, imem_req); end
    endtask

    task automatic test_pc_write();
        retire(32'h104, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL seq_fetch: got req=%b addr=%h expected 1 00000104", imem_req, imem_addr); end
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL seq_pc: got %h expected 00000104", pc); end
        fetch_to_valid(32'h0000_0013);
        checks++; if (inst_pc !== 32'h104) begin errors++; $display("FAIL seq_inst_pc: got %h expected 00000104", inst_pc); end
        accept();
        retire(32'h2000, 1'b0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin errors++; $display("FAIL jalr_fetch: got req=%b addr=%h expected 1 00002000", imem_req, imem_addr); end
    endtask

    task automatic test_stalls();
        int bad;
        bad = 0;
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (imem_req !== 1'b1 || imem_addr !== 32'h2000) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL gnt_stall: got %0d bad cycles expected 0", bad); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (imem_req !== 1'b0 || inst_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rvalid_stall: got %0d bad cycles expected 0", bad); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hFFFF_FFFF;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || inst_pc !== 32'h2000 || fetch_count !== 32'd2) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ready_stall: got %0d bad cycles expected 0", bad); end
        accept();
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL stall_count: got %0d expected 3", fetch_count); end
    endtask

    task automatic test_fault();
        int bad;
        retire(32'h106, 1'b0);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_flag: got %b expected 1", fault); end
        checks++; if (pc !== 32'h106) begin errors++; $display("FAIL fault_pc: got %h expected 00000106", pc); end
        bad = 0;
        imem_gnt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (imem_req !== 1'b0 || fault !== 1'b1) bad++;
            tick();
        end
        imem_gnt = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL fault_quiet: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_halt();
        do_reset();
        #1;
        checks++; if (fault !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL fault_cleared: got fault=%b addr=%h expected 0 00000100", fault, imem_addr); end
        retire(32'h0000_0999, 1'b0);
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (pc !== 32'h100 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL spurious_req: got pc=%h req=%b valid=%b expected 00000100 1 0", pc, imem_req, inst_valid); end
        fetch_to_valid(32'hAAAA_0001);
        retire(32'h300, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_5555;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (pc !== 32'h100 || inst_valid !== 1'b1 || inst !== 32'hAAAA_0001) begin errors++; $display("FAIL spurious_valid: got pc=%h valid=%b inst=%h expected 00000100 1 aaaa0001", pc, inst_valid, inst); end
        accept();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++; if (halted !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_no_write: got halted=%b req=%b expected 0 0", halted, imem_req); end
        retire(32'h200, 1'b1);
        checks++; if (halted !== 1'b1 || pc !== 32'h200 || imem_req !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL halt_taken: got halted=%b pc=%h req=%b fault=%b expected 1 00000200 0 0", halted, pc, imem_req, fault); end
        imem_rvalid = 1'b1;
        retire(32'h400, 1'b0);
        imem_rvalid = 1'b0;
        tick();
        checks++; if (pc !== 32'h200 || halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL halt_hold: got pc=%h halted=%b req=%b valid=%b expected 00000200 1 0 0", pc, halted, imem_req, inst_valid); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL halt_count: got %0d expected 1", fetch_count); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL stale_rvalid: got valid=%b req=%b addr=%h expected 0 1 00000100", inst_valid, imem_req, imem_addr); end
        checks++; if (inst !== 32'd0) begin errors++; $display("FAIL stale_inst: got %h expected 0", inst); end
        force dut.fetch_count_q = 32'hFFFF_FFFF;
        #2;
        release dut.fetch_count_q;
        checks++; if (fetch_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_preset: got %h expected ffffffff", fetch_count); end
        fetch_to_valid(32'h0000_0073);
        checks++; if (inst_pc !== 32'h100 || inst !== 32'h0000_0073) begin errors++; $display("FAIL refetch: got pc=%h inst=%h expected 00000100 00000073", inst_pc, inst); end
        accept();
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL count_wrap: got %h expected 0", fetch_count); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        inst_ready  = 1'b0;
        pc_write    = 1'b0;
        next_pc     = 32'd0;
        halt        = 1'b0;
        test_reset();
        test_basic_fetch();
        test_pc_write();
        test_stalls();
        test_fault();
        test_halt();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
